// File: rtl/map9_pkg.sv
// Shared types and widths for the map9 engine scheduler.
package map9_pkg;

  localparam int unsigned N_W  = 9;
  localparam int unsigned DP_W = 9;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StArm,
    StRun,
    StResp
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping upward.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  id_o,
  output logic            any_o
);

  always_comb begin
    logic [IDW:0] idx;
    idx   = '0;
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      // ptr and k are both below NREQ, so one subtraction wraps the sum.
      idx = {1'b0, ptr_i} + (IDW + 1)'(k);
      if (idx >= (IDW + 1)'(NREQ)) begin
        idx = idx - (IDW + 1)'(NREQ);
      end
      if (!any_o && req_i[idx[IDW-1:0]]) begin
        gnt_o[idx[IDW-1:0]] = 1'b1;
        id_o                = idx[IDW-1:0];
        any_o               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/map9_sched.sv
// Round-robin scheduler sharing one map9v3 engine among NREQ requesters.
module map9_sched
  import map9_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned START_HOLD = 3,
  parameter int unsigned TIMEOUT    = 1023,
  parameter int unsigned IDW        = $clog2(NREQ)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [N_W*NREQ-1:0] req_n,
  output logic [NREQ-1:0]     req_ready,
  output logic                eng_start,
  output logic [N_W-1:0]      eng_n,
  input  logic                eng_done,
  input  logic [DP_W-1:0]     eng_dp,
  output logic                rsp_valid,
  output logic [IDW-1:0]      rsp_id,
  output logic [DP_W-1:0]     rsp_dp,
  output logic                rsp_timeout,
  output logic                busy
);

  // One counter serves both the start-hold phase and the ARM/RUN timeout.
  localparam int unsigned CntMax = (TIMEOUT > START_HOLD) ? TIMEOUT : START_HOLD;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [CntW-1:0] cnt_q;

  logic [N_W-1:0]  req_arr [NREQ];
  logic [NREQ-1:0] pick_gnt;
  logic [IDW-1:0]  pick_id;
  logic            pick_any;
  logic [IDW-1:0]  ptr_nxt;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_arr[i] = req_n[i*N_W +: N_W];
    end
  end

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .id_o  (pick_id),
    .any_o (pick_any)
  );

  assign ptr_nxt = (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + 1'b1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      cnt_q       <= '0;
      req_ready   <= '0;
      eng_start   <= 1'b0;
      eng_n       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_dp      <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick_any) begin
            req_ready <= pick_gnt;
            eng_n     <= req_arr[pick_id];
            rsp_id    <= pick_id;
            ptr_q     <= ptr_nxt;
            cnt_q     <= '0;
            busy      <= 1'b1;
            state_q   <= StLaunch;
          end
        end
        StLaunch: begin
          // The grant cycle itself leaves start low; START_HOLD high cycles follow.
          if (cnt_q == CntW'(START_HOLD)) begin
            eng_start <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StArm;
          end else begin
            eng_start <= 1'b1;
            cnt_q     <= cnt_q + 1'b1;
          end
        end
        StArm, StRun: begin
          if (state_q == StRun && eng_done) begin
            rsp_dp      <= eng_dp;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state_q     <= StResp;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            rsp_dp      <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            // A done still high here belongs to the previous operation.
            if (state_q == StArm && !eng_done) begin
              state_q <= StRun;
            end
          end
        end
        StResp: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
